// File: rtl/mem_arbiter_if.sv
// Bundles the port-0, port-1 and simram signals of the memory arbiter.
// slave is the arbiter's view; master is the cpu / agent / memory side.
interface mem_arbiter_if #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 16
);
    logic [AWIDTH-1:0] p0_raddr;
    logic              p0_rd;
    logic [DWIDTH-1:0] p0_rdata;
    logic [AWIDTH-1:0] p0_waddr;
    logic [DWIDTH-1:0] p0_wdata;
    logic              p0_wr;

    logic              p1_req;
    logic              p1_we;
    logic [AWIDTH-1:0] p1_addr;
    logic [DWIDTH-1:0] p1_wdata;
    logic              p1_ack;
    logic [DWIDTH-1:0] p1_rdata;
    logic              p1_rvalid;
    logic [15:0]       p1_stall_cnt;

    logic [AWIDTH-1:0] mem_raddr;
    logic              mem_re;
    logic [DWIDTH-1:0] mem_rdata;
    logic [AWIDTH-1:0] mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_we;

    modport slave (
        input  p0_raddr, p0_rd, p0_waddr, p0_wdata, p0_wr,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_rdata,
        output p1_ack, p1_rdata, p1_rvalid, p1_stall_cnt,
        output mem_raddr, mem_re, mem_waddr, mem_wdata, mem_we
    );

    modport master (
        output p0_raddr, p0_rd, p0_waddr, p0_wdata, p0_wr,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_rdata,
        input  p1_ack, p1_rdata, p1_rvalid, p1_stall_cnt,
        input  mem_raddr, mem_re, mem_waddr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one dual-port simram between the cpu (port 0, never stalled) and a
// req/ack debug/DMA agent (port 1) that is slotted into idle read/write cycles.
module mem_arbiter #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 16,
    parameter int RDLAT  = 1
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              holdWe_q, holdWe_d;
    logic [AWIDTH-1:0] holdAddr_q, holdAddr_d;
    logic [DWIDTH-1:0] holdWdata_q, holdWdata_d;
    logic [15:0]       stallCnt_q, stallCnt_d;
    logic [RDLAT-1:0]  tagPipe_q, tagPipe_d;

    logic p1Pend;
    logic p1WrIssue;
    logic p1RdIssue;
    logic p1Blocked;

    // Port 1 issues only from PEND and never while reset is held.
    always_comb begin
        p1Pend    = (state_q == PEND) && !reset;
        p1WrIssue = p1Pend &&  holdWe_q && !bus.p0_wr;
        p1RdIssue = p1Pend && !holdWe_q && !bus.p0_rd;
        p1Blocked = p1Pend && !p1WrIssue && !p1RdIssue;
    end

    always_comb begin
        state_d     = state_q;
        holdWe_d    = holdWe_q;
        holdAddr_d  = holdAddr_q;
        holdWdata_d = holdWdata_q;
        stallCnt_d  = stallCnt_q;

        case (state_q)
            IDLE: begin
                if (bus.p1_req) begin
                    state_d     = PEND;
                    holdWe_d    = bus.p1_we;
                    holdAddr_d  = bus.p1_addr;
                    holdWdata_d = bus.p1_wdata;
                end
            end
            PEND: begin
                if (p1WrIssue || p1RdIssue) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (p1Blocked && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end

        // Tag 1 marks a port-1 read; port-0 reads and empty slots shift in 0.
        tagPipe_d    = tagPipe_q << 1;
        tagPipe_d[0] = p1RdIssue;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            holdWe_q    <= 1'b0;
            holdAddr_q  <= '0;
            holdWdata_q <= '0;
            stallCnt_q  <= '0;
            tagPipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            holdWe_q    <= holdWe_d;
            holdAddr_q  <= holdAddr_d;
            holdWdata_q <= holdWdata_d;
            stallCnt_q  <= stallCnt_d;
            tagPipe_q   <= tagPipe_d;
        end
    end

    // Port 0 always owns a memory port it strobes; port 1 fills the gap.
    always_comb begin
        bus.mem_re    = 1'b0;
        bus.mem_raddr = '0;
        if (bus.p0_rd) begin
            bus.mem_re    = 1'b1;
            bus.mem_raddr = bus.p0_raddr;
        end else if (p1RdIssue) begin
            bus.mem_re    = 1'b1;
            bus.mem_raddr = holdAddr_q;
        end
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        if (bus.p0_wr) begin
            bus.mem_we    = 1'b1;
            bus.mem_waddr = bus.p0_waddr;
            bus.mem_wdata = bus.p0_wdata;
        end else if (p1WrIssue) begin
            bus.mem_we    = 1'b1;
            bus.mem_waddr = holdAddr_q;
            bus.mem_wdata = holdWdata_q;
        end
    end

    assign bus.p1_ack       = p1WrIssue | p1RdIssue;
    assign bus.p1_rvalid    = tagPipe_q[RDLAT-1] && !reset;
    assign bus.p1_rdata     = bus.p1_rvalid ? bus.mem_rdata : '0;
    assign bus.p0_rdata     = bus.mem_rdata;
    assign bus.p1_stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RDLAT=1 and one with RDLAT=3,
// both driven by the same stimulus, each backed by a small simram model.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        p0Rd;
    logic [15:0] p0Raddr;
    logic        p0Wr;
    logic [15:0] p0Waddr;
    logic [15:0] p0Wdata;
    logic        p1Req;
    logic        p1We;
    logic [15:0] p1Addr;
    logic [15:0] p1Wdata;

    int testCount = 0;
    int failCount = 0;

    mem_arbiter_if #(.AWIDTH(16), .DWIDTH(16)) bus1 ();
    mem_arbiter_if #(.AWIDTH(16), .DWIDTH(16)) bus3 ();

    mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .RDLAT(1)) dut1 (
        .clk   (clock),
        .reset (reset),
        .bus   (bus1)
    );

    mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .RDLAT(3)) dut3 (
        .clk   (clock),
        .reset (reset),
        .bus   (bus3)
    );

    assign bus1.p0_rd    = p0Rd;
    assign bus1.p0_raddr = p0Raddr;
    assign bus1.p0_wr    = p0Wr;
    assign bus1.p0_waddr = p0Waddr;
    assign bus1.p0_wdata = p0Wdata;
    assign bus1.p1_req   = p1Req;
    assign bus1.p1_we    = p1We;
    assign bus1.p1_addr  = p1Addr;
    assign bus1.p1_wdata = p1Wdata;

    assign bus3.p0_rd    = p0Rd;
    assign bus3.p0_raddr = p0Raddr;
    assign bus3.p0_wr    = p0Wr;
    assign bus3.p0_waddr = p0Waddr;
    assign bus3.p0_wdata = p0Wdata;
    assign bus3.p1_req   = p1Req;
    assign bus3.p1_we    = p1We;
    assign bus3.p1_addr  = p1Addr;
    assign bus3.p1_wdata = p1Wdata;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural simram models: write on the edge, read data RDLAT cycles after re.
    logic [15:0] ram1 [256];
    logic [15:0] ram3 [256];
    logic [15:0] rd1Pipe;
    logic [15:0] rd3Pipe [3];

    always @(posedge clock) begin
        if (bus1.mem_we) ram1[bus1.mem_waddr[7:0]] <= bus1.mem_wdata;
        rd1Pipe <= ram1[bus1.mem_raddr[7:0]];
    end

    always @(posedge clock) begin
        if (bus3.mem_we) ram3[bus3.mem_waddr[7:0]] <= bus3.mem_wdata;
        rd3Pipe[0] <= ram3[bus3.mem_raddr[7:0]];
        rd3Pipe[1] <= rd3Pipe[0];
        rd3Pipe[2] <= rd3Pipe[1];
    end

    assign bus1.mem_rdata = rd1Pipe;
    assign bus3.mem_rdata = rd3Pipe[2];

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic rst,
                                 input logic rd, input logic [15:0] raddr,
                                 input logic wr, input logic [15:0] waddr, input logic [15:0] wdata,
                                 input logic req, input logic we,
                                 input logic [15:0] addr, input logic [15:0] pwdata);
        @(negedge clock);
        reset   = rst;
        p0Rd    = rd;
        p0Raddr = raddr;
        p0Wr    = wr;
        p0Waddr = waddr;
        p0Wdata = wdata;
        p1Req   = req;
        p1We    = we;
        p1Addr  = addr;
        p1Wdata = pwdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic        expRvalid [5];
    logic [15:0] expRdata  [5];

    initial begin
        reset   = 1'b1;
        p0Rd    = 1'b0;
        p0Raddr = 16'h0;
        p0Wr    = 1'b0;
        p0Waddr = 16'h0;
        p0Wdata = 16'h0;
        p1Req   = 1'b0;
        p1We    = 1'b0;
        p1Addr  = 16'h0;
        p1Wdata = 16'h0;

        // Reset: port 0 passes through, port 1 stays silent even with req high.
        applyStimulus(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        applyStimulus(1, 0, 16'h0, 1, 16'h0005, 16'h1234, 1, 1, 16'h0020, 16'h5555);
        checkOutput("rst_ack",    bus1.p1_ack, 0);
        checkOutput("rst_rvalid", bus1.p1_rvalid, 0);
        checkOutput("rst_rdata",  bus1.p1_rdata, 0);
        checkOutput("rst_stall",  bus1.p1_stall_cnt, 0);
        checkOutput("rst_we",     bus1.mem_we, 1);
        checkOutput("rst_waddr",  bus1.mem_waddr, 32'h0005);
        checkOutput("rst_wdata",  bus1.mem_wdata, 32'h1234);
        checkOutput("rst_re",     bus1.mem_re, 0);

        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("idle_we",    bus1.mem_we, 0);
        checkOutput("idle_waddr", bus1.mem_waddr, 0);
        checkOutput("idle_wdata", bus1.mem_wdata, 0);
        checkOutput("idle_ack",   bus1.p1_ack, 0);

        // Test 1: p1 write, p0 idle.
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'h0010, 16'hBEEF);
        checkOutput("t1_capture_ack", bus1.p1_ack, 0);
        checkOutput("t1_capture_we",  bus1.mem_we, 0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'h0010, 16'hBEEF);
        checkOutput("t1_ack",   bus1.p1_ack, 1);
        checkOutput("t1_we",    bus1.mem_we, 1);
        checkOutput("t1_waddr", bus1.mem_waddr, 32'h0010);
        checkOutput("t1_wdata", bus1.mem_wdata, 32'hBEEF);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t1_ack_drop", bus1.p1_ack, 0);

        // Test 2: p1 read returns one cycle after ack.
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 16'h0010, 16'h0);
        checkOutput("t2_capture_ack", bus1.p1_ack, 0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 16'h0010, 16'h0);
        checkOutput("t2_ack",    bus1.p1_ack, 1);
        checkOutput("t2_re",     bus1.mem_re, 1);
        checkOutput("t2_raddr",  bus1.mem_raddr, 32'h0010);
        checkOutput("t2_rv_T",   bus1.p1_rvalid, 0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t2_rv_T1",    bus1.p1_rvalid, 1);
        checkOutput("t2_rdata_T1", bus1.p1_rdata, 32'hBEEF);
        checkOutput("t2_p0rdata",  bus1.p0_rdata, 32'hBEEF);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t2_rv_T2",    bus1.p1_rvalid, 0);
        checkOutput("t2_rdata_T2", bus1.p1_rdata, 0);

        // Test 3: p0 writes block a pending p1 write for five cycles.
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'h0020, 16'hCAFE);
        checkOutput("t3_capture_ack", bus1.p1_ack, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 16'h0, 1, 16'h0030, 16'h1111, 1, 1, 16'h0020, 16'hCAFE);
            checkOutput("t3_blocked_ack",   bus1.p1_ack, 0);
            checkOutput("t3_blocked_waddr", bus1.mem_waddr, 32'h0030);
            checkOutput("t3_blocked_stall", bus1.p1_stall_cnt, i);
        end
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'h0020, 16'hCAFE);
        checkOutput("t3_ack",   bus1.p1_ack, 1);
        checkOutput("t3_waddr", bus1.mem_waddr, 32'h0020);
        checkOutput("t3_wdata", bus1.mem_wdata, 32'hCAFE);
        checkOutput("t3_stall", bus1.p1_stall_cnt, 5);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t3_stall_hold", bus1.p1_stall_cnt, 5);
        checkOutput("t3_ack_drop",   bus1.p1_ack, 0);

        // Test 4: p0 read and p1 write issue together.
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'h0040, 16'h4444);
        applyStimulus(0, 1, 16'h0010, 0, 16'h0, 16'h0, 1, 1, 16'h0040, 16'h4444);
        checkOutput("t4_ack",   bus1.p1_ack, 1);
        checkOutput("t4_we",    bus1.mem_we, 1);
        checkOutput("t4_waddr", bus1.mem_waddr, 32'h0040);
        checkOutput("t4_wdata", bus1.mem_wdata, 32'h4444);
        checkOutput("t4_re",    bus1.mem_re, 1);
        checkOutput("t4_raddr", bus1.mem_raddr, 32'h0010);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t4_p0rdata", bus1.p0_rdata, 32'hBEEF);
        checkOutput("t4_rvalid",  bus1.p1_rvalid, 0);
        checkOutput("t4_p1rdata", bus1.p1_rdata, 0);

        // Test 5: reset lands while a p1 read is in flight.
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 16'h0040, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 16'h0040, 16'h0);
        checkOutput("t5_ack1", bus1.p1_ack, 1);
        checkOutput("t5_ack3", bus3.p1_ack, 1);
        applyStimulus(1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t5_rst_rvalid1", bus1.p1_rvalid, 0);
        checkOutput("t5_rst_ack1",    bus1.p1_ack, 0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t5_rvalid1", bus1.p1_rvalid, 0);
        checkOutput("t5_rvalid3", bus3.p1_rvalid, 0);
        checkOutput("t5_stall",   bus1.p1_stall_cnt, 0);
        checkOutput("t5_state",   dut1.state_q, 0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t5_rvalid3_T3", bus3.p1_rvalid, 0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t5_rvalid3_T4", bus3.p1_rvalid, 0);

        // A pending write dropped by reset is never acked afterwards.
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'h0050, 16'h5050);
        applyStimulus(1, 0, 16'h0, 0, 16'h0, 16'h0, 1, 1, 16'h0050, 16'h5050);
        checkOutput("t5_pend_rst_ack", bus1.p1_ack, 0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t5_pend_drop_ack", bus1.p1_ack, 0);
        checkOutput("t5_pend_drop_we",  bus1.mem_we, 0);

        // Test 6 (RDLAT=3): p0 read, p1 read, p0 read back to back.
        applyStimulus(0, 1, 16'h0010, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0);
        checkOutput("t6_p0a_raddr", bus3.mem_raddr, 32'h0010);
        checkOutput("t6_p0a_ack",   bus3.p1_ack, 0);
        applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0);
        checkOutput("t6_p1_ack",   bus3.p1_ack, 1);
        checkOutput("t6_p1_raddr", bus3.mem_raddr, 32'h0020);

        expRvalid = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        expRdata  = '{16'h0, 16'h0, 16'hCAFE, 16'h0, 16'h0};
        applyStimulus(0, 1, 16'h0030, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("t6_p0b_raddr", bus3.mem_raddr, 32'h0030);
        checkOutput("t6_rvalid",    bus3.p1_rvalid, expRvalid[0]);
        checkOutput("t6_rdata",     bus3.p1_rdata, expRdata[0]);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
            checkOutput("t6_rvalid", bus3.p1_rvalid, expRvalid[i]);
            checkOutput("t6_rdata",  bus3.p1_rdata, expRdata[i]);
            if (i == 1) checkOutput("t6_p0a_rdata", bus3.p0_rdata, 32'hBEEF);
            if (i == 3) checkOutput("t6_p0b_rdata", bus3.p0_rdata, 32'h1111);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
